decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered RV32I instruction-decode pipeline stage with XLEN-parametrised immediate generation. It sits between fetch and register-read/execute. It adds valid/ready handshaking with a 2-entry skid buffer, a pipeline flush, instruction-format classification, illegal-instruction detection and operand-use flags for the hazard unit.

Parameters:
XLEN, 32, datapath width (32 or 64); immediates are sign-extended to XLEN, and PC is XLEN wide.
SKID_EN, 1, 1 = 2-entry skid buffer (full throughput); 0 = single entry, in_ready_o = !out_valid_o | out_ready_i.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  discard all held entries
in_valid_i  in  1  fetch has an instruction
in_ready_o  out  1  stage can accept
instr_i  in  32  raw instruction
pc_i  in  XLEN  instruction PC
out_valid_o  out  1  decoded entry available
out_ready_i  in  1  downstream accepts
pc_o  out  XLEN  PC of the output entry
opcode_o  out  7  instr[6:0]
funct3_o  out  3  instr[14:12]
funct7_o  out  7  instr[31:25]
rd_addr_o  out  5  instr[11:7]
rs1_addr_o  out  5  instr[19:15]
rs2_addr_o  out  5  instr[24:20]
imm_o  out  XLEN  sign-extended immediate
fmt_o  out  3  0 = R, 1 = I, 2 = S, 3 = B, 4 = U, 5 = J, 7 = none/illegal
illegal_o  out  1  illegal encoding
rs1_used_o  out  1  rs1 is read
rs2_used_o  out  1  rs2 is read
rd_we_o  out  1  writes rd (forced 0 when rd = x0)

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: every output register is 0 and out_valid_o = 0. in_ready_o = 1 from the first cycle after reset. Inputs are ignored while rst_i = 1.
- Decode: decode is combinational on instr_i and is captured on acceptance, so results are carried with the entry.
  - Latency: exactly 1 cycle from the in_valid_i & in_ready_o edge to out_valid_o.
- Immediate encoding, per opcode:
  - I (0010011, 0000011, 1100111): sext(instr[31:20]).
  - S (0100011): sext({instr[31:25], instr[11:7]}).
  - B (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - J (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - U (0110111, 0010111): sext({instr[31:12], 12'b0}).
  - For XLEN = 64, U-type is sign-extended from bit 31.
  - Every other opcode gives imm_o = 0. FENCE (0001111) and SYSTEM (1110011) are fmt = I with imm = sext(instr[31:20]).
- Illegal cases, each forcing illegal_o = 1, imm_o = 0, fmt_o = 7 and all use/we flags = 0:
  - instr[1:0] != 11, or an opcode outside the 11 listed.
  - R-type (0110011): funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101.
  - OP-IMM shifts: funct3 001 with funct7 != 0; funct3 101 with funct7 not 0000000/0100000.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 >= 011.
  - Branch funct3 in {010, 011}.
  - JALR funct3 != 000.
- Operand-use flags:
  - rs1_used_o = 1 for R, I (except FENCE), S and B.
  - rs2_used_o = 1 for R, S and B.
  - rd_we_o = 1 for R, OP-IMM, LOAD, JALR, JAL, LUI and AUIPC, and only when rd != 0.
  - Raw fields (opcode_o, funct3_o, funct7_o, rd/rs1/rs2_addr_o) always pass through unchanged.
- Buffer states:
  - EMPTY: out_valid_o = 0, in_ready_o = 1.
  - ONE: main entry valid, in_ready_o = 1.
  - FULL: main and skid entries valid, in_ready_o = 0.
  - in_ready_o is a function of state only, with no combinational path from out_ready_i. This does not apply when SKID_EN = 0.
- State transitions (push = in_valid_i & in_ready_o, pop = out_valid_o & out_ready_i):
  - EMPTY + push → ONE.
  - ONE + push & !pop → FULL; the new entry goes to the skid entry.
  - ONE + push & pop → ONE; main takes the new entry.
  - ONE + pop & !push → EMPTY.
  - FULL + pop → ONE; skid moves to main.
  - Outputs always present the oldest entry, so order is strictly FIFO.
- Output stability: while out_valid_o = 1 and out_ready_i = 0, all outputs hold stable.
- Flush: flush_i = 1 → next state EMPTY and out_valid_o = 0 next cycle, regardless of push/pop in the same cycle. A simultaneous push is dropped. flush_i combined with rst_i is treated as reset.
- Reset mid-operation: discards all entries, the same as flush.

Test Plan:
1. Push 0xFFF00093 (addi x1,x0,-1), pc 0x100, out_ready_i = 1 → next cycle: out_valid_o = 1, imm_o = 0xFFFFFFFF, fmt_o = 1, rd_addr_o = 1, rd_we_o = 1, rs1_used_o = 1, rs2_used_o = 0, pc_o = 0x100.
2. Push 0xFE208EE3 (beq x1,x2,-4) → imm_o = 0xFFFFFFFC, fmt_o = 3, rs1_used_o = rs2_used_o = 1, rd_we_o = 0.
3. Backpressure: out_ready_i = 0, offer 3 instructions back-to-back → first two accepted, in_ready_o = 0 after the second, outputs frozen on the first. Raise out_ready_i → all three emerge in order, one per cycle.
4. Illegal: push 0x00000000 and 0x0000B0B3 (funct7 = 0, funct3 = 011, legal) then 0x4000B0B3 (funct7 = 0100000, funct3 = 011) → illegal_o = 1, 0, 1; imm_o = 0 and rd_we_o = 0 on the illegal entries.
5. In state FULL, assert flush_i together with in_valid_i → next cycle out_valid_o = 0, in_ready_o = 1, nothing emerges later. Repeat with rst_i mid-stream → same result.
6. XLEN = 64: push 0x800000B7 (lui x1,0x80000) → imm_o = 0xFFFFFFFF80000000, fmt_o = 4, rs1_used_o = 0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: field extraction, immediate generation, legality
// check and hazard flags, behind a valid/ready buffer with optional skid.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [4:0]      rd_addr_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o,
  output logic            rs1_used_o,
  output logic            rs2_used_o,
  output logic            rd_we_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
    logic            rs1u;
    logic            rs2u;
    logic            rdwe;
  } ent_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t      r_state;
  ent_t        r_main;
  ent_t        r_skid;
  ent_t        w_ent;
  logic [31:0] w_imm;
  logic [2:0]  w_fmt;
  logic        w_ill;
  logic        w_rs1u;
  logic        w_rs2u;
  logic        w_rdwe;
  logic        w_push;
  logic        w_pop;

  wire [6:0] w_opc = instr_i[6:0];
  wire [2:0] w_f3  = instr_i[14:12];
  wire [6:0] w_f7  = instr_i[31:25];

  wire [31:0] w_imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  wire [31:0] w_imm_s = {{20{instr_i[31]}}, instr_i[31:25],
                         instr_i[11:7]};
  wire [31:0] w_imm_b = {{20{instr_i[31]}}, instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
  wire [31:0] w_imm_j = {{12{instr_i[31]}}, instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
  wire [31:0] w_imm_u = {instr_i[31:12], 12'b0};

  always_comb begin
    w_imm  = '0;
    w_fmt  = 3'd7;
    w_ill  = 1'b0;
    w_rs1u = 1'b0;
    w_rs2u = 1'b0;
    w_rdwe = 1'b0;
    unique case (w_opc)
      7'b0110011: begin
        w_fmt  = 3'd0;
        w_rs1u = 1'b1;
        w_rs2u = 1'b1;
        w_rdwe = 1'b1;
        w_ill  = !(w_f7 == 7'b0000000 ||
                  (w_f7 == 7'b0100000 &&
                   (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      7'b0010011: begin
        w_fmt  = 3'd1;
        w_imm  = w_imm_i;
        w_rs1u = 1'b1;
        w_rdwe = 1'b1;
        w_ill  = (w_f3 == 3'b001 && w_f7 != 7'b0000000) ||
                 (w_f3 == 3'b101 && w_f7 != 7'b0000000 &&
                  w_f7 != 7'b0100000);
      end
      7'b0000011: begin
        w_fmt  = 3'd1;
        w_imm  = w_imm_i;
        w_rs1u = 1'b1;
        w_rdwe = 1'b1;
        w_ill  = (w_f3 == 3'b011) || (w_f3 == 3'b110) ||
                 (w_f3 == 3'b111);
      end
      7'b0100011: begin
        w_fmt  = 3'd2;
        w_imm  = w_imm_s;
        w_rs1u = 1'b1;
        w_rs2u = 1'b1;
        w_ill  = (w_f3 >= 3'b011);
      end
      7'b1100011: begin
        w_fmt  = 3'd3;
        w_imm  = w_imm_b;
        w_rs1u = 1'b1;
        w_rs2u = 1'b1;
        w_ill  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      7'b1100111: begin
        w_fmt  = 3'd1;
        w_imm  = w_imm_i;
        w_rs1u = 1'b1;
        w_rdwe = 1'b1;
        w_ill  = (w_f3 != 3'b000);
      end
      7'b1101111: begin
        w_fmt  = 3'd5;
        w_imm  = w_imm_j;
        w_rdwe = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        w_fmt  = 3'd4;
        w_imm  = w_imm_u;
        w_rdwe = 1'b1;
      end
      7'b0001111: begin
        w_fmt  = 3'd1;
        w_imm  = w_imm_i;
      end
      7'b1110011: begin
        w_fmt  = 3'd1;
        w_imm  = w_imm_i;
        w_rs1u = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal encodings carry no immediate and raise no hazards.
    if (w_ill) begin
      w_imm  = '0;
      w_fmt  = 3'd7;
      w_rs1u = 1'b0;
      w_rs2u = 1'b0;
      w_rdwe = 1'b0;
    end
    if (instr_i[11:7] == 5'd0) w_rdwe = 1'b0;
  end

  always_comb begin
    w_ent      = '0;
    w_ent.pc   = pc_i;
    w_ent.ins  = instr_i;
    w_ent.imm  = XLEN'($signed(w_imm));
    w_ent.fmt  = w_fmt;
    w_ent.ill  = w_ill;
    w_ent.rs1u = w_rs1u;
    w_ent.rs2u = w_rs2u;
    w_ent.rdwe = w_rdwe;
  end

  assign out_valid_o = (r_state != S_EMPTY);
  assign in_ready_o  = SKID_EN ? (r_state != S_FULL)
                               : (!out_valid_o || out_ready_i);
  assign w_push = in_valid_i & in_ready_o;
  assign w_pop  = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush_i) begin
      r_state <= S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_main  <= w_ent;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            r_main <= w_ent;
          end else if (w_push) begin
            r_skid  <= w_ent;
            r_state <= S_FULL;
          end else if (w_pop) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            r_main  <= r_skid;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign pc_o       = r_main.pc;
  assign opcode_o   = r_main.ins[6:0];
  assign funct3_o   = r_main.ins[14:12];
  assign funct7_o   = r_main.ins[31:25];
  assign rd_addr_o  = r_main.ins[11:7];
  assign rs1_addr_o = r_main.ins[19:15];
  assign rs2_addr_o = r_main.ins[24:20];
  assign imm_o      = r_main.imm;
  assign fmt_o      = r_main.fmt;
  assign illegal_o  = r_main.ill;
  assign rs1_used_o = r_main.rs1u;
  assign rs2_used_o = r_main.rs2u;
  assign rd_we_o    = r_main.rdwe;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors, FIFO order,
// backpressure, flush/reset and a 64-bit immediate instance.
module tb_decode_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic        r1;
    logic        r2;
    logic        we;
    logic [4:0]  rd;
    logic [6:0]  opc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [31:0] imm_o;
  logic [2:0]  fmt_o;
  logic        ill_o;
  logic        r1_o;
  logic        r2_o;
  logic        we_o;

  logic        v64_in = 1'b0;
  logic        r64_in;
  logic [31:0] i64 = '0;
  logic        v64_out;
  logic [63:0] pc64_o;
  logic [6:0]  opc64_o;
  logic [2:0]  f3_64_o;
  logic [6:0]  f7_64_o;
  logic [4:0]  rd64_o;
  logic [4:0]  rs1_64_o;
  logic [4:0]  rs2_64_o;
  logic [63:0] imm64_o;
  logic [2:0]  fmt64_o;
  logic        ill64_o;
  logic        r1_64_o;
  logic        r2_64_o;
  logic        we64_o;

  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pc_o(pc_o), .opcode_o(opcode_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .rd_addr_o(rd_o), .rs1_addr_o(rs1_o),
    .rs2_addr_o(rs2_o), .imm_o(imm_o), .fmt_o(fmt_o),
    .illegal_o(ill_o), .rs1_used_o(r1_o), .rs2_used_o(r2_o),
    .rd_we_o(we_o)
  );

  decode_stage #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
    .in_valid_i(v64_in), .in_ready_o(r64_in),
    .instr_i(i64), .pc_i(64'h200),
    .out_valid_o(v64_out), .out_ready_i(1'b1),
    .pc_o(pc64_o), .opcode_o(opc64_o), .funct3_o(f3_64_o),
    .funct7_o(f7_64_o), .rd_addr_o(rd64_o), .rs1_addr_o(rs1_64_o),
    .rs2_addr_o(rs2_64_o), .imm_o(imm64_o), .fmt_o(fmt64_o),
    .illegal_o(ill64_o), .rs1_used_o(r1_64_o), .rs2_used_o(r2_64_o),
    .rd_we_o(we64_o)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] p, input logic [31:0] im,
                              input logic [2:0] f, input logic il,
                              input logic a, input logic b,
                              input logic w, input logic [4:0] d,
                              input logic [6:0] o);
    exp_t e;
    e.pc = p; e.imm = im; e.fmt = f; e.ill = il;
    e.r1 = a; e.r2 = b; e.we = w; e.rd = d; e.opc = o;
    return e;
  endfunction

  // Monitor: compare the head of the queue whenever an entry is shown.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {32'b0, pc_o}, 64'hDEAD);
        end else begin
          chk("pc",      pc_o,     q[0].pc);
          chk("imm",     imm_o,    q[0].imm);
          chk("fmt",     fmt_o,    q[0].fmt);
          chk("illegal", ill_o,    q[0].ill);
          chk("rs1_used", r1_o,    q[0].r1);
          chk("rs2_used", r2_o,    q[0].r2);
          chk("rd_we",   we_o,     q[0].we);
          chk("rd_addr", rd_o,     q[0].rd);
          chk("opcode",  opcode_o, q[0].opc);
          if (out_ready) begin
            void'(q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  task automatic push(input logic [31:0] ins, input logic [31:0] p,
                      input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1;
    instr = ins;
    pc = p;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        break;
      end
      n++;
      if (n > 50) begin
        chk("push_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic kill_full(input bit use_rst);
    out_ready = 1'b0;
    push(32'h00500113, 32'h300, mk(32'h300, 5, 1, 0, 1, 0, 1, 2, 7'h13));
    push(32'h00700193, 32'h304, mk(32'h304, 7, 1, 0, 1, 0, 1, 3, 7'h13));
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    instr = 32'h123452B7;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    flush = 1'b0;
    q.delete();
    @(negedge clk);
    chk("kill_out_valid", out_valid, 0);
    chk("kill_in_ready", in_ready, 1);
    out_ready = 1'b1;
    idle(5);
  endtask

  initial begin
    int p0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imm", imm_o, 0);
    chk("rst_pc", pc_o, 0);
    @(posedge clk); #1;

    out_ready = 1'b1;
    push(32'hFFF00093, 32'h100,
         mk(32'h100, 32'hFFFFFFFF, 1, 0, 1, 0, 1, 1, 7'h13));
    push(32'hFE208EE3, 32'h104,
         mk(32'h104, 32'hFFFFFFFC, 3, 0, 1, 1, 0, 29, 7'h63));
    drain();

    out_ready = 1'b0;
    fork
      begin
        push(32'h00500113, 32'h200, mk(32'h200, 5, 1, 0, 1, 0, 1, 2, 7'h13));
        push(32'h00700193, 32'h204, mk(32'h204, 7, 1, 0, 1, 0, 1, 3, 7'h13));
        push(32'h123452B7, 32'h208,
             mk(32'h208, 32'h12345000, 4, 0, 0, 0, 1, 5, 7'h37));
      end
    join_none
    idle(4);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_queued", q.size(), 2);
    chk("bp_head_pc", pc_o, 32'h200);
    @(posedge clk); #1;
    p0 = pops;
    out_ready = 1'b1;
    idle(3);
    chk("bp_one_per_cycle", pops - p0, 3);
    drain();

    push(32'h00000000, 32'h400, mk(32'h400, 0, 7, 1, 0, 0, 0, 0, 7'h00));
    push(32'h0000B0B3, 32'h404, mk(32'h404, 0, 0, 0, 1, 1, 1, 1, 7'h33));
    push(32'h4000B0B3, 32'h408, mk(32'h408, 0, 7, 1, 0, 0, 0, 1, 7'h33));
    drain();

    kill_full(1'b0);
    kill_full(1'b1);
    chk("kill_queue_empty", q.size(), 0);

    v64_in = 1'b1;
    i64 = 32'h800000B7;
    @(posedge clk); #1;
    v64_in = 1'b0;
    @(negedge clk);
    chk("x64_valid", v64_out, 1);
    chk("x64_imm", imm64_o, 64'hFFFFFFFF80000000);
    chk("x64_fmt", fmt64_o, 4);
    chk("x64_rs1_used", r1_64_o, 0);
    chk("x64_rd_we", we64_o, 1);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
